// File: rtl/matrix_3x3_gen.sv
// 3x3 window generator: two line buffers plus column taps, registered outputs one cycle after accept.
// No back-pressure; gaps in in_vld simply hold the window state.
module matrix_3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8,
  localparam int CW   = $clog2(IMG_W),
  localparam int RW   = $clog2(IMG_H)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_start,
  input  logic            in_vld,
  input  logic [DW-1:0]   in_data,
  output logic            win_vld,
  output logic [9*DW-1:0] win_data,
  output logic [RW-1:0]   win_row,
  output logic [CW-1:0]   win_col,
  output logic            frame_done
);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [3*DW-1:0] tap0_q, tap0_d;
  logic [3*DW-1:0] tap1_q, tap1_d;
  logic            win_vld_q, win_vld_d;
  logic [9*DW-1:0] win_data_q, win_data_d;
  logic [RW-1:0]   win_row_q, win_row_d;
  logic [CW-1:0]   win_col_q, win_col_d;
  logic            frame_done_q, frame_done_d;

  logic [DW-1:0]   lb0_q [IMG_W];
  logic [DW-1:0]   lb1_q [IMG_W];

  logic [CW-1:0]   cur_col;
  logic [RW-1:0]   cur_row;
  logic [3*DW-1:0] tap0_cur, tap1_cur, new_tap;
  logic            last_col, last_row;

  // frame_start acts as if the counters and taps were already cleared, so a
  // coincident pixel is taken as (0,0) in the same cycle.
  always_comb begin
    cur_col  = frame_start ? '0 : col_q;
    cur_row  = frame_start ? '0 : row_q;
    tap0_cur = frame_start ? '0 : tap0_q;
    tap1_cur = frame_start ? '0 : tap1_q;
    new_tap  = {lb1_q[cur_col], lb0_q[cur_col], in_data};
    last_col = (cur_col == CW'(IMG_W - 1));
    last_row = (cur_row == RW'(IMG_H - 1));

    col_d        = cur_col;
    row_d        = cur_row;
    tap0_d       = tap0_cur;
    tap1_d       = tap1_cur;
    win_vld_d    = 1'b0;
    win_data_d   = win_data_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    frame_done_d = 1'b0;

    if (in_vld) begin
      col_d  = last_col ? '0 : cur_col + CW'(1);
      if (last_col) begin
        row_d = last_row ? '0 : cur_row + RW'(1);
      end
      tap0_d = tap1_cur;
      tap1_d = new_tap;
      frame_done_d = last_col && last_row;
      // Only interior centres qualify; stale line-buffer rows are never exposed.
      if (cur_row >= RW'(2) && cur_col >= CW'(2)) begin
        win_vld_d  = 1'b1;
        win_data_d = {tap0_cur[3*DW-1 -: DW], tap1_cur[3*DW-1 -: DW], new_tap[3*DW-1 -: DW],
                      tap0_cur[2*DW-1 -: DW], tap1_cur[2*DW-1 -: DW], new_tap[2*DW-1 -: DW],
                      tap0_cur[DW-1:0],       tap1_cur[DW-1:0],       new_tap[DW-1:0]};
        win_row_d  = cur_row - RW'(1);
        win_col_d  = cur_col - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      tap0_q       <= '0;
      tap1_q       <= '0;
      win_vld_q    <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      tap0_q       <= tap0_d;
      tap1_q       <= tap1_d;
      win_vld_q    <= win_vld_d;
      win_data_q   <= win_data_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers carry no reset; their contents are masked by the valid rule.
  always_ff @(posedge clk) begin
    if (in_vld) begin
      lb1_q[cur_col] <= lb0_q[cur_col];
      lb0_q[cur_col] <= in_data;
    end
  end

  assign win_vld    = win_vld_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Scoreboard bench for matrix_3x3_gen at 8x6: expected windows are built from pixel = row*16+col.
module tb_matrix_3x3_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        in_vld = 1'b0;
  logic [7:0]  in_data = '0;
  logic        win_vld;
  logic [71:0] win_data;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        frame_done;

  matrix_3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .in_vld      (in_vld),
    .in_data     (in_data),
    .win_vld     (win_vld),
    .win_data    (win_data),
    .win_row     (win_row),
    .win_col     (win_col),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          win_cnt = 0;
  int          done_cnt = 0;
  logic [71:0] last_data = '0;

  task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  function automatic logic [71:0] win_of(input int cr, input int cc);
    logic [71:0] d;
    d = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        d[(8 - (i * 3 + j)) * 8 +: 8] = 8'((cr - 1 + i) * 16 + (cc - 1 + j));
    return d;
  endfunction

  // One clock: drive, push expectation, then sample 1 time unit after the edge.
  task automatic drive(input logic fs, input logic v, input int r, input int c);
    exp_t e;
    logic qual;
    frame_start = fs;
    in_vld      = v;
    in_data     = v ? 8'(r * 16 + c) : 8'hA5;
    qual        = v && (r >= 2) && (c >= 2);
    if (qual) begin
      e.data = win_of(r - 1, c - 1);
      e.row  = 3'(r - 1);
      e.col  = 3'(c - 1);
      e.done = (r == H - 1) && (c == W - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    in_vld      = 1'b0;
    if (win_vld === 1'b1) win_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    check_val("win_vld", 72'(win_vld), 72'(qual));
    if (qual) begin
      if (sb.size() == 0) begin
        check_val("sb_empty", 72'(1), 72'(0));
      end else begin
        e = sb.pop_front();
        check_val("win_data", win_data, e.data);
        check_val("win_row", 72'(win_row), 72'(e.row));
        check_val("win_col", 72'(win_col), 72'(e.col));
        check_val("frame_done", 72'(frame_done), 72'(e.done));
        last_data = e.data;
      end
    end else begin
      check_val("win_hold", win_data, last_data);
      check_val("frame_done_idle", 72'(frame_done), 72'(0));
    end
  endtask

  task automatic send_frame(input logic fs_first, input bit gaps, input int npix);
    for (int n = 0; n < npix; n++) begin
      if (gaps) begin
        for (int k = 0; k < 4 && $urandom_range(1) == 0; k++) drive(1'b0, 1'b0, 0, 0);
      end
      drive(fs_first && (n == 0), 1'b1, n / W, n % W);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_vld"},  72'(win_vld), 72'(0));
    check_val({tag, "_data"}, win_data, 72'(0));
    check_val({tag, "_row"},  72'(win_row), 72'(0));
    check_val({tag, "_col"},  72'(win_col), 72'(0));
    check_val({tag, "_done"}, 72'(frame_done), 72'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame
    win_cnt = 0; done_cnt = 0;
    send_frame(1'b1, 1'b0, W * H);
    check_val("s1_windows", 72'(win_cnt), 72'(24));
    check_val("s1_done", 72'(done_cnt), 72'(1));

    // Random gaps
    win_cnt = 0; done_cnt = 0;
    send_frame(1'b1, 1'b1, W * H);
    check_val("s2_windows", 72'(win_cnt), 72'(24));
    check_val("s2_done", 72'(done_cnt), 72'(1));

    // Two frames back-to-back, no frame_start
    win_cnt = 0; done_cnt = 0;
    send_frame(1'b0, 1'b0, W * H);
    send_frame(1'b0, 1'b0, W * H);
    check_val("s3_windows", 72'(win_cnt), 72'(48));
    check_val("s3_done", 72'(done_cnt), 72'(2));

    // Abort at (3,4): frame_start arrives with that pixel, taken as (0,0)
    win_cnt = 0; done_cnt = 0;
    send_frame(1'b0, 1'b0, 3 * W + 4);
    check_val("s4_abort_done", 72'(done_cnt), 72'(0));
    win_cnt = 0;
    send_frame(1'b1, 1'b0, W * H);
    check_val("s4_windows", 72'(win_cnt), 72'(24));
    check_val("s4_done", 72'(done_cnt), 72'(1));

    // Reset asserted at (2,5)
    send_frame(1'b1, 1'b0, 2 * W + 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    last_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    win_cnt = 0; done_cnt = 0;
    send_frame(1'b0, 1'b0, W * H);
    check_val("s5_windows", 72'(win_cnt), 72'(24));
    check_val("s5_done", 72'(done_cnt), 72'(1));
    check_val("sb_drained", 72'(sb.size()), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
